// File: rtl/dbi_bus_arbiter_if.sv
// dbi_bus_arbiter_if
//   Bundles the requester side and the shared-link side of the DBI bus arbiter.
//   master : requesters / link consumer (drive req, data_in, dbi_en; observe the rest)
//   slave  : the arbiter itself
//   Signals:
//     dbi_en    1 = AC-DBI encoding on, 0 = raw pass-through
//     req       per-requester request, held with data until granted
//     data_in   requester i's word at data_in[i*bw +: bw]
//     grant     one-hot combinational grant
//     bus_out   {dbi_flag, payload}, registered
//     bus_valid bus_out holds a new word this cycle
//     src_id    requester whose word is on bus_out
//     inv_count saturating count of inverted words
interface dbi_bus_arbiter_if #(
    parameter int bw   = 32,
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
);
    logic                 dbi_en;
    logic [NREQ-1:0]      req;
    logic [NREQ*bw-1:0]   data_in;
    logic [NREQ-1:0]      grant;
    logic [bw:0]          bus_out;
    logic                 bus_valid;
    logic [IW-1:0]        src_id;
    logic [15:0]          inv_count;

    modport master (
        output dbi_en, req, data_in,
        input  grant, bus_out, bus_valid, src_id, inv_count
    );

    modport slave (
        input  dbi_en, req, data_in,
        output grant, bus_out, bus_valid, src_id, inv_count
    );
endinterface

// File: rtl/dbi_bus_arbiter.sv
// dbi_bus_arbiter
//   Round-robin arbiter sharing one AC-DBI encoded link among NREQ requesters.
//   Each granted word is compared with the payload currently on the link; if
//   more than half the bits would toggle (and dbi_en is set) the word is sent
//   inverted with the MSB flag set.
//   Ports:
//     clk    clock, all state on posedge
//     reset  synchronous, active-high
//     bus    dbi_bus_arbiter_if.slave (req/data_in/dbi_en in; grant/bus_out/
//            bus_valid/src_id/inv_count out)
module dbi_bus_arbiter #(
    parameter int bw   = 32,
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    dbi_bus_arbiter_if.slave  bus
);

    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] grant_c;
    logic [IW-1:0]   gnt_idx;
    logic            found;
    logic [bw-1:0]   gnt_data;
    int              hd;
    logic            inv;

    // Rotating priority search starting at ptr; first requester found wins.
    always_comb begin
        int j;
        grant_c = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found   = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        if (reset) found = 1'b0;
        if (found) grant_c[gnt_idx] = 1'b1;
    end

    assign bus.grant = grant_c;

    // Hamming distance is measured against the payload on the wire, which
    // is held through idle cycles, so idle gaps never add toggles.
    assign gnt_data = bus.data_in[gnt_idx*bw +: bw];
    assign hd       = $countones(gnt_data ^ bus.bus_out[bw-1:0]);
    assign inv      = bus.dbi_en && (hd > bw/2);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            bus.bus_out   <= '0;
            bus.bus_valid <= 1'b0;
            bus.src_id    <= '0;
            bus.inv_count <= '0;
        end else if (found) begin
            ptr           <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
            bus.bus_out   <= inv ? {1'b1, ~gnt_data} : {1'b0, gnt_data};
            bus.bus_valid <= 1'b1;
            bus.src_id    <= gnt_idx;
            if (inv && bus.inv_count != 16'hFFFF)
                bus.inv_count <= bus.inv_count + 16'd1;
        end else begin
            bus.bus_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbi_bus_arbiter.sv
module tb_dbi_bus_arbiter;
    localparam int BW = 32;
    localparam int NR = 4;

    logic clk;
    logic reset;

    dbi_bus_arbiter_if #(.bw(BW), .NREQ(NR)) bus ();

    dbi_bus_arbiter #(.bw(BW), .NREQ(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Requester-side state
    logic [NR-1:0] pending;
    logic [BW-1:0] pdata [NR];

    // Reference model of the link
    int            m_ptr;
    logic [BW-1:0] m_payload;
    logic          m_flag;
    logic          m_valid;
    int            m_src;
    int            m_inv;
    logic [BW-1:0] m_sent;
    logic [NR-1:0] seen_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive();
        bus.req = pending;
        for (int i = 0; i < NR; i++) bus.data_in[i*BW +: BW] = pdata[i];
    endtask

    function automatic logic [BW-1:0] decode(input logic [BW:0] w);
        return w[BW] ? ~w[BW-1:0] : w[BW-1:0];
    endfunction

    // One clock: inputs already set at negedge; check grant, advance model at
    // posedge, check registered outputs at the following negedge.
    task automatic tick();
        int gi;
        int h;
        logic [NR-1:0] eg;
        drive();
        #1;
        gi = -1;
        if (!reset)
            for (int k = 0; k < NR; k++)
                if (gi < 0 && pending[(m_ptr + k) % NR]) gi = (m_ptr + k) % NR;
        eg = (gi >= 0) ? NR'(1) << gi : '0;
        seen_grant = bus.grant;
        chk("grant", bus.grant, eg);
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_payload = '0; m_flag = 0; m_valid = 0; m_src = 0; m_inv = 0;
        end else if (gi >= 0) begin
            m_sent = pdata[gi];
            h = $countones(m_sent ^ m_payload);
            if (bus.dbi_en && h > BW/2) begin
                m_flag = 1; m_payload = ~m_sent;
                if (m_inv < 65535) m_inv++;
            end else begin
                m_flag = 0; m_payload = m_sent;
            end
            m_valid = 1; m_src = gi; m_ptr = (gi + 1) % NR;
            pending[gi] = 1'b0;
        end else begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("bus_valid", bus.bus_valid, m_valid);
        chk("bus_out", bus.bus_out, {m_flag, m_payload});
        chk("src_id", bus.src_id, m_src[1:0]);
        chk("inv_count", bus.inv_count, m_inv[15:0]);
        if (m_valid) chk("roundtrip", decode(bus.bus_out), m_sent);
        drive();
    endtask

    initial begin
        pending = '0;
        for (int i = 0; i < NR; i++) pdata[i] = '0;
        m_ptr = 0; m_payload = '0; m_flag = 0; m_valid = 0; m_src = 0; m_inv = 0;
        m_sent = '0;
        bus.dbi_en = 1'b1;
        reset = 1'b1;
        drive();
        @(negedge clk);
        pending[3] = 1'b1; pdata[3] = 32'h1234_5678;
        tick();
        chk("grant_in_reset", seen_grant, 4'b0000);
        chk("reset_bus_out", bus.bus_out, 33'h0);
        pending[3] = 1'b0;
        reset = 1'b0;

        // 1: all-ones after reset payload 0 -> inverted
        pending[0] = 1'b1; pdata[0] = 32'hFFFF_FFFF;
        tick();
        chk("t1_grant", seen_grant, 4'b0001);
        chk("t1_bus_out", bus.bus_out, 33'h1_0000_0000);
        chk("t1_inv", bus.inv_count, 16'd1);

        // 3: tie (h=16) against payload 0 -> not inverted
        pending[0] = 1'b1; pdata[0] = 32'h0000_FFFF;
        tick();
        chk("t3_bus_out", bus.bus_out, 33'h0_0000_FFFF);
        chk("t3_inv", bus.inv_count, 16'd1);

        // 4: dbi disabled
        reset = 1'b1; tick(); reset = 1'b0;
        bus.dbi_en = 1'b0;
        pending[2] = 1'b1; pdata[2] = 32'hFFFF_FFFF;
        tick();
        chk("t4_grant", seen_grant, 4'b0100);
        chk("t4_bus_out", bus.bus_out, 33'h0_FFFF_FFFF);

        // 5: idle cycles hold payload; next word compared with held value
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_idle_valid", bus.bus_valid, 1'b0);
            chk("t5_idle_hold", bus.bus_out, 33'h0_FFFF_FFFF);
        end
        bus.dbi_en = 1'b1;
        pending[1] = 1'b1; pdata[1] = 32'h0;
        tick();
        chk("t5_held_cmp", bus.bus_out, 33'h1_FFFF_FFFF);

        // 2: all requesting, strict rotation
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pending = 4'b1111;
            for (int i = 0; i < NR; i++) if (k == 0 || seen_grant[i]) pdata[i] = $urandom;
            tick();
            chk("t2_rotate", seen_grant, 4'b0001 << (k % 4));
            chk("t2_valid", bus.bus_valid, 1'b1);
        end

        // 6: reset mid-stream with req=0110 held
        pending = '0;
        for (int k = 0; k < 3; k++) begin
            pending[1] = 1'b1; pending[2] = 1'b1;
            tick();
        end
        pending[1] = 1'b1; pending[2] = 1'b1;
        reset = 1'b1;
        tick();
        chk("t6_grant_rst", seen_grant, 4'b0000);
        chk("t6_valid_rst", bus.bus_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk("t6_first_grant", seen_grant, 4'b0010);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: pdata[i] = $urandom;
                        1: pdata[i] = ~m_payload;
                        2: pdata[i] = m_payload ^ 32'h0000_FFFF;
                        default: pdata[i] = m_payload ^ 32'h0001_FFFF;
                    endcase
                end
            end
            bus.dbi_en = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
